bb_mem_ctrl: RTL and testbench
==============================

BB_MEM_CTRL -- requirements
Module: bb_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the bus word width, equal to the core's `DATA_WIDTH.
REQ-002 SHALL have parameter ADDR_BITS, default 8, giving DEPTH = 2^ADDR_BITS words.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_mem_oen  input  2  read strobes from the core: [1]=AR data read, [0]=PC fetch.
REQ-006 SHALL have port i_mem_ien  input  2  write strobes from the core: [1]=write at AR, [0]=write at PC.
REQ-007 SHALL have port i_mem_addr  input  DATA_WIDTH  AR address from the core.
REQ-008 SHALL have port i_mem_pc  input  DATA_WIDTH  PC address from the core.
REQ-009 SHALL have port i_mem_data  input  DATA_WIDTH  write data from the core.
REQ-010 SHALL have port o_mem_data  output  DATA_WIDTH  registered read data returned to the core.
REQ-011 SHALL have port i_load_en  input  1  external loader request.
REQ-012 SHALL have port i_load_we  input  1  loader write strobe, valid only in LOAD.
REQ-013 SHALL have port i_load_addr  input  ADDR_BITS  loader write address.
REQ-014 SHALL have port i_load_data  input  DATA_WIDTH  loader write data.
REQ-015 SHALL have port o_ready  output  1  high only in RUN; the core may access only while it is high.
REQ-016 SHALL have port o_conflict  output  1  sticky flag set on simultaneous dual-port access.

Function
REQ-017 SHALL contain a DEPTH x DATA_WIDTH storage array.
REQ-018 SHALL index the array with the low ADDR_BITS of i_mem_addr and i_mem_pc; upper bits are ignored, so addresses alias and wrap.
REQ-019 SHALL implement an FSM with states CLEAR, LOAD and RUN.
REQ-020 CLEAR SHALL write zero to word clr_cnt each cycle, clr_cnt counting 0 to DEPTH-1, one word per cycle.
REQ-021 CLEAR SHALL exit after writing word DEPTH-1: to LOAD if i_load_en=1, otherwise to RUN.
REQ-022 CLEAR SHALL therefore last exactly DEPTH cycles after reset release; i_load_en SHALL not shorten it.
REQ-023 LOAD SHALL write i_load_data to word i_load_addr in every cycle with i_load_we=1.
REQ-024 LOAD SHALL move to RUN in the cycle after i_load_en is sampled 0.
REQ-025 RUN SHALL move to LOAD when i_load_en is sampled 1; core strobes in that same cycle are still serviced.
REQ-026 In RUN, a read SHALL register the array word into o_mem_data at the next edge, giving one-cycle latency.
REQ-027 i_mem_oen[1] SHALL read word i_mem_addr.
REQ-028 i_mem_oen[0] alone SHALL read word i_mem_pc.
REQ-029 When both i_mem_oen bits are 1, the AR read SHALL win.
REQ-030 When both i_mem_oen bits are 0, o_mem_data SHALL be 0 the next cycle, because the core ORs it onto a shared bus.
REQ-031 i_mem_ien[1] SHALL write i_mem_data to word i_mem_addr.
REQ-032 i_mem_ien[0] alone SHALL write i_mem_data to word i_mem_pc.
REQ-033 When both i_mem_ien bits are 1, only the AR write SHALL occur.
REQ-034 A read and a write to the same word in the same cycle SHALL return the old data (read-before-write).
REQ-035 o_conflict SHALL set when i_mem_oen==2'b11 or i_mem_ien==2'b11 in RUN, and SHALL be cleared only by reset.
REQ-036 Outside RUN, core strobes SHALL be ignored, o_mem_data SHALL be 0, and no core write SHALL occur.
REQ-037 o_ready SHALL be a registered decode of state==RUN.

Reset
REQ-038 While rst=1, the block SHALL hold state=CLEAR, clr_cnt=0, o_mem_data=0, o_ready=0 and o_conflict=0.
REQ-039 Asserting rst mid-operation, including mid-LOAD, SHALL restart CLEAR; array contents are then re-zeroed.

Verification
REQ-040 Release rst with i_load_en=0 -> o_ready rises after DEPTH (256) cycles; a read of any address returns 0.
REQ-041 In RUN, i_mem_ien=2'b10, addr=0x0005, data=0xBEEF; next cycle oen=2'b10 at addr 0x0105 -> o_mem_data=0xBEEF one cycle later (alias).
REQ-042 oen=2'b11 with mem[AR]=0x1111 and mem[PC]=0x2222 -> o_mem_data=0x1111 and o_conflict=1, remaining 1 afterwards.
REQ-043 Same-cycle write 0x00AA and read of word 3 holding 0x0055 -> returns 0x0055; the next read returns 0x00AA.
REQ-044 From RUN, raise i_load_en and load 0x1234 at address 7, then drop i_load_en -> o_ready stays 0 during LOAD, and a PC fetch of word 7 returns 0x1234.
REQ-045 Pulse rst during LOAD -> o_ready=0 and o_conflict=0, and word 7 reads 0 after CLEAR completes.

Source files
------------

// File: rtl/bb_mem_ctrl_if.sv
// Core/loader bus of the bb_mem_ctrl block: core strobes and addresses, loader port,
// registered read data and status flags.
interface bb_mem_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_BITS  = 8
);
  logic [1:0]            i_mem_oen;
  logic [1:0]            i_mem_ien;
  logic [DATA_WIDTH-1:0] i_mem_addr;
  logic [DATA_WIDTH-1:0] i_mem_pc;
  logic [DATA_WIDTH-1:0] i_mem_data;
  logic [DATA_WIDTH-1:0] o_mem_data;
  logic                  i_load_en;
  logic                  i_load_we;
  logic [ADDR_BITS-1:0]  i_load_addr;
  logic [DATA_WIDTH-1:0] i_load_data;
  logic                  o_ready;
  logic                  o_conflict;

  modport master (
    output i_mem_oen, i_mem_ien, i_mem_addr, i_mem_pc, i_mem_data,
    output i_load_en, i_load_we, i_load_addr, i_load_data,
    input  o_mem_data, o_ready, o_conflict
  );

  modport slave (
    input  i_mem_oen, i_mem_ien, i_mem_addr, i_mem_pc, i_mem_data,
    input  i_load_en, i_load_we, i_load_addr, i_load_data,
    output o_mem_data, o_ready, o_conflict
  );
endinterface

// File: rtl/bb_mem_ctrl.sv
// Single-port memory shared by a core (AR/PC ports) and an external loader.
// Clears itself after reset, then optionally loads, then serves the core in RUN.
module bb_mem_ctrl #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_BITS  = 8
) (
  input logic         clk,
  input logic         rst,
  bb_mem_ctrl_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [1:0] {StClear, StLoad, StRun} state_e;

  state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]  clr_cnt_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_BITS-1:0]  ar_idx, pc_idx;
  logic                  we;
  logic [ADDR_BITS-1:0]  waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
  logic                  ready_d, ready_q;
  logic                  conflict_d, conflict_q;

  // Upper address bits are deliberately dropped so addresses alias.
  assign ar_idx = bus.i_mem_addr[ADDR_BITS-1:0];
  assign pc_idx = bus.i_mem_pc[ADDR_BITS-1:0];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_mem_addr[DATA_WIDTH-1:ADDR_BITS],
                              bus.i_mem_pc[DATA_WIDTH-1:ADDR_BITS]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StClear;
      clr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StClear) clr_cnt_q <= clr_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StClear: if (&clr_cnt_q) state_d = bus.i_load_en ? StLoad : StRun;
      StLoad:  if (!bus.i_load_en) state_d = StRun;
      StRun:   if (bus.i_load_en) state_d = StLoad;
      default: state_d = StClear;
    endcase
  end

  always_comb begin
    we         = 1'b0;
    waddr      = clr_cnt_q;
    wdata      = '0;
    rdata_d    = '0;
    conflict_d = conflict_q;
    ready_d    = (state_d == StRun);
    unique case (state_q)
      StClear: we = 1'b1;
      StLoad: begin
        if (bus.i_load_we) begin
          we    = 1'b1;
          waddr = bus.i_load_addr;
          wdata = bus.i_load_data;
        end
      end
      StRun: begin
        wdata = bus.i_mem_data;
        if (bus.i_mem_ien[1]) begin
          we    = 1'b1;
          waddr = ar_idx;
        end else if (bus.i_mem_ien[0]) begin
          we    = 1'b1;
          waddr = pc_idx;
        end
        if (bus.i_mem_oen[1])      rdata_d = mem[ar_idx];
        else if (bus.i_mem_oen[0]) rdata_d = mem[pc_idx];
        if (bus.i_mem_oen == 2'b11 || bus.i_mem_ien == 2'b11) conflict_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Read data samples the array before this edge's write lands: read-before-write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus.o_mem_data = rdata_q;
  assign bus.o_ready    = ready_q;
  assign bus.o_conflict = conflict_q;
endmodule

// File: tb/tb_bb_mem_ctrl.sv
// Directed bench for bb_mem_ctrl: reset/clear timing, vector table in RUN, load and
// reset-during-load sequences.
module tb_bb_mem_ctrl;
  localparam int unsigned DW = 16;
  localparam int unsigned AB = 8;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  bb_mem_ctrl_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) bus ();

  bb_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  oen;
    logic [1:0]  ien;
    logic [15:0] addr;
    logic [15:0] pc;
    logic [15:0] wdata;
    logic [15:0] exp_data;
    logic        exp_conflict;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_core();
    bus.i_mem_oen  = 2'b00;
    bus.i_mem_ien  = 2'b00;
    bus.i_mem_addr = '0;
    bus.i_mem_pc   = '0;
    bus.i_mem_data = '0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    idle_core();
    bus.i_load_en   = 1'b0;
    bus.i_load_we   = 1'b0;
    bus.i_load_addr = '0;
    bus.i_load_data = '0;

    //               oen    ien    addr      pc        wdata     exp_data  conflict
    vecs[0]  = '{2'b10, 2'b00, 16'h0033, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{2'b01, 2'b00, 16'h0000, 16'h00FF, 16'h0000, 16'h0000, 1'b0};
    vecs[2]  = '{2'b00, 2'b10, 16'h0005, 16'h0000, 16'hBEEF, 16'h0000, 1'b0};
    vecs[3]  = '{2'b10, 2'b00, 16'h0105, 16'h0000, 16'h0000, 16'hBEEF, 1'b0};
    vecs[4]  = '{2'b00, 2'b01, 16'h0000, 16'h0003, 16'h0055, 16'h0000, 1'b0};
    vecs[5]  = '{2'b10, 2'b10, 16'h0003, 16'h0000, 16'h00AA, 16'h0055, 1'b0};
    vecs[6]  = '{2'b01, 2'b00, 16'h0000, 16'h0203, 16'h0000, 16'h00AA, 1'b0};
    vecs[7]  = '{2'b00, 2'b10, 16'h0010, 16'h0000, 16'h1111, 16'h0000, 1'b0};
    vecs[8]  = '{2'b00, 2'b01, 16'h0000, 16'h0020, 16'h2222, 16'h0000, 1'b0};
    vecs[9]  = '{2'b01, 2'b00, 16'h0000, 16'h0020, 16'h0000, 16'h2222, 1'b0};
    vecs[10] = '{2'b00, 2'b00, 16'h0010, 16'h0020, 16'h0000, 16'h0000, 1'b0};
    vecs[11] = '{2'b11, 2'b00, 16'h0010, 16'h0020, 16'h0000, 16'h1111, 1'b1};
    vecs[12] = '{2'b00, 2'b00, 16'h0010, 16'h0020, 16'h0000, 16'h0000, 1'b1};
    vecs[13] = '{2'b00, 2'b11, 16'h0040, 16'h0041, 16'h7777, 16'h0000, 1'b1};
    vecs[14] = '{2'b10, 2'b00, 16'h0040, 16'h0000, 16'h0000, 16'h7777, 1'b1};
    vecs[15] = '{2'b01, 2'b00, 16'h0000, 16'h0041, 16'h0000, 16'h0000, 1'b1};

    // Reset values
    repeat (2) step();
    check("rst_ready", 32'(bus.o_ready), 32'd0);
    check("rst_conflict", 32'(bus.o_conflict), 32'd0);
    check("rst_data", 32'(bus.o_mem_data), 32'd0);

    // Clear takes exactly 256 cycles
    rst = 1'b0;
    repeat (255) step();
    check("clear_ready_early", 32'(bus.o_ready), 32'd0);
    step();
    check("clear_ready_done", 32'(bus.o_ready), 32'd1);

    foreach (vecs[i]) begin
      bus.i_mem_oen  = vecs[i].oen;
      bus.i_mem_ien  = vecs[i].ien;
      bus.i_mem_addr = vecs[i].addr;
      bus.i_mem_pc   = vecs[i].pc;
      bus.i_mem_data = vecs[i].wdata;
      step();
      check($sformatf("vec%0d_data", i), 32'(bus.o_mem_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d_conflict", i), 32'(bus.o_conflict), 32'(vecs[i].exp_conflict));
      check($sformatf("vec%0d_ready", i), 32'(bus.o_ready), 32'd1);
    end

    // RUN -> LOAD: the request cycle still serves the core
    idle_core();
    bus.i_load_en  = 1'b1;
    bus.i_mem_oen  = 2'b10;
    bus.i_mem_addr = 16'h0040;
    step();
    check("load_entry_data", 32'(bus.o_mem_data), 32'h7777);
    check("load_entry_ready", 32'(bus.o_ready), 32'd0);
    bus.i_load_we   = 1'b1;
    bus.i_load_addr = 8'd7;
    bus.i_load_data = 16'h1234;
    bus.i_mem_ien   = 2'b10;
    bus.i_mem_addr  = 16'h0007;
    bus.i_mem_data  = 16'hDEAD;
    step();
    check("load_core_ignored", 32'(bus.o_mem_data), 32'd0);
    check("load_ready", 32'(bus.o_ready), 32'd0);
    idle_core();
    bus.i_load_we = 1'b0;
    bus.i_load_en = 1'b0;
    step();
    check("load_exit_ready", 32'(bus.o_ready), 32'd1);
    bus.i_mem_oen = 2'b01;
    bus.i_mem_pc  = 16'h0007;
    step();
    check("load_fetch", 32'(bus.o_mem_data), 32'h1234);
    check("conflict_sticky", 32'(bus.o_conflict), 32'd1);

    // Reset in the middle of LOAD; load_en held high must not shorten CLEAR
    idle_core();
    bus.i_load_en = 1'b1;
    step();
    bus.i_load_we   = 1'b1;
    bus.i_load_addr = 8'd7;
    bus.i_load_data = 16'h5555;
    #2 rst = 1'b1;
    #1;
    check("midload_rst_ready", 32'(bus.o_ready), 32'd0);
    check("midload_rst_conflict", 32'(bus.o_conflict), 32'd0);
    check("midload_rst_data", 32'(bus.o_mem_data), 32'd0);
    @(negedge clk);
    bus.i_load_we = 1'b0;
    rst = 1'b0;
    repeat (255) step();
    check("reclear_ready_early", 32'(bus.o_ready), 32'd0);
    step();
    check("reclear_to_load", 32'(bus.o_ready), 32'd0);
    bus.i_load_en = 1'b0;
    step();
    check("reclear_run_ready", 32'(bus.o_ready), 32'd1);
    bus.i_mem_oen = 2'b01;
    bus.i_mem_pc  = 16'h0007;
    step();
    check("reclear_word7", 32'(bus.o_mem_data), 32'd0);
    bus.i_mem_oen  = 2'b10;
    bus.i_mem_addr = 16'h0105;
    step();
    check("reclear_word5", 32'(bus.o_mem_data), 32'd0);
    check("reclear_conflict", 32'(bus.o_conflict), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
